// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the I-cache, D-cache and physical-memory handshake signals that
// meet at the memory port arbiter.
//   slave  : arbiter view (takes requests and pmem responses, drives grants)
//   master : environment view (caches + memory model)
// Signals:
//   icache_read/address -> icache_rdata/resp     I-side line read
//   dcache_read/write/address/wdata -> dcache_rdata/resp   D-side line access
//   pmem_read/write/address/wdata <- pmem_rdata/resp       memory port
//   arb_busy                                                arbiter not idle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              icache_read;
  logic [ADDR_W-1:0] icache_address;
  logic [LINE_W-1:0] icache_rdata;
  logic              icache_resp;

  logic              dcache_read;
  logic              dcache_write;
  logic [ADDR_W-1:0] dcache_address;
  logic [LINE_W-1:0] dcache_wdata;
  logic [LINE_W-1:0] dcache_rdata;
  logic              dcache_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  logic              arb_busy;

  modport slave (
    input  icache_read, icache_address,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  pmem_rdata, pmem_resp,
    output icache_rdata, icache_resp,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output arb_busy
  );

  modport master (
    output icache_read, icache_address,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    output pmem_rdata, pmem_resp,
    input  icache_rdata, icache_resp,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  arb_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one physical-memory port between the I-cache and D-cache, one
// transaction at a time. D requests win, but after MAX_D_STREAK consecutive
// D grants with an I request waiting, the I side is forced through.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; aborts any transaction in flight
//   bus    mem_port_arbiter_if.slave (request, response and pmem signals)
//
// state   | meaning
// IDLE    | no transaction; arbitrate on this edge
// SERVE_I | I-side read in flight, waiting for pmem_resp
// SERVE_D | D-side read or write in flight, waiting for pmem_resp
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int LINE_W       = 128,
  parameter int MAX_D_STREAK = 4
) (
  input logic clk,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t              r_state;
  logic [STREAK_W-1:0] r_d_streak;
  logic                r_pmem_read;
  logic                r_pmem_write;
  logic [ADDR_W-1:0]   r_pmem_address;
  logic [LINE_W-1:0]   r_pmem_wdata;

  logic w_d_req;
  logic w_grant_d;
  logic w_grant_i;

  assign w_d_req   = bus.dcache_read | bus.dcache_write;
  assign w_grant_d = w_d_req & (~bus.icache_read |
                                (r_d_streak < STREAK_W'(MAX_D_STREAK)));
  assign w_grant_i = bus.icache_read & ~w_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_d_streak     <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state        <= SERVE_D;
            r_pmem_address <= bus.dcache_address;
            // Read+write together is treated as a write.
            if (bus.dcache_write) begin
              r_pmem_write <= 1'b1;
              r_pmem_wdata <= bus.dcache_wdata;
            end else begin
              r_pmem_read <= 1'b1;
            end
            // Streak only counts D grants that made a waiting I request wait longer.
            if (bus.icache_read) begin
              r_d_streak <= (r_d_streak == STREAK_W'(MAX_D_STREAK)) ?
                            r_d_streak : r_d_streak + STREAK_W'(1);
            end else begin
              r_d_streak <= '0;
            end
          end else if (w_grant_i) begin
            r_state        <= SERVE_I;
            r_pmem_address <= bus.icache_address;
            r_pmem_read    <= 1'b1;
            r_d_streak     <= '0;
          end
        end
        SERVE_I, SERVE_D: begin
          // Always return to IDLE: the forced idle cycle lets a requester
          // drop its request after resp without being re-granted.
          if (bus.pmem_resp) begin
            r_state      <= IDLE;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pmem_read  <= 1'b0;
          r_pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_wdata   = r_pmem_wdata;
  assign bus.arb_busy     = (r_state != IDLE);

  // Response routing is combinational so the requester sees resp in the
  // same cycle memory completes.
  assign bus.icache_resp  = (r_state == SERVE_I) & bus.pmem_resp;
  assign bus.dcache_resp  = (r_state == SERVE_D) & bus.pmem_resp;
  assign bus.icache_rdata = (r_state == SERVE_I) ? bus.pmem_rdata : '0;
  assign bus.dcache_rdata = (r_state == SERVE_D) ? bus.pmem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: reset values, single I read,
// D-over-I priority, starvation limit, address hold, stray pmem_resp and
// asynchronous reset abort. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .MAX_D_STREAK(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                     input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a strobe, completes it immediately, reports who was served.
  task automatic serve_one(output logic got_d, output logic [ADDR_W-1:0] got_addr);
    int k;
    k = 0;
    while (!(bus.pmem_read || bus.pmem_write) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("serve_timeout", LINE_W'(k < 20), LINE_W'(1));
    got_addr = bus.pmem_address;
    bus.pmem_resp = 1'b1;
    #1;
    got_d = bus.dcache_resp;
    chk("serve_one_resp", LINE_W'(bus.icache_resp ^ bus.dcache_resp), LINE_W'(1));
    @(negedge clk);
    bus.pmem_resp = 1'b0;
  endtask

  logic              got_d;
  logic [ADDR_W-1:0] got_addr;
  logic              exp_d [6];
  int                d_done;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    #1;
    chk("rst_pmem_read",  LINE_W'(bus.pmem_read),    '0);
    chk("rst_pmem_write", LINE_W'(bus.pmem_write),   '0);
    chk("rst_busy",       LINE_W'(bus.arb_busy),     '0);
    chk("rst_addr",       LINE_W'(bus.pmem_address), '0);
    chk("rst_wdata",      bus.pmem_wdata,            '0);
    @(negedge clk);
    reset = 1'b0;

    // Single I read, memory responds 3 cycles after strobe.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h1230;
    @(negedge clk);
    chk("i_strobe", LINE_W'(bus.pmem_read), LINE_W'(1));
    chk("i_addr",   LINE_W'(bus.pmem_address), LINE_W'(16'h1230));
    chk("i_busy",   LINE_W'(bus.arb_busy), LINE_W'(1));
    chk("i_no_resp_early", LINE_W'(bus.icache_resp), '0);
    @(negedge clk);
    @(negedge clk);
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {16{8'hA5}};
    #1;
    chk("i_resp",    LINE_W'(bus.icache_resp), LINE_W'(1));
    chk("i_rdata",   bus.icache_rdata, {16{8'hA5}});
    chk("i_d_resp0", LINE_W'(bus.dcache_resp), '0);
    chk("i_d_rdata0", bus.dcache_rdata, '0);
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    chk("i_strobe_drop", LINE_W'(bus.pmem_read), '0);
    chk("i_idle",        LINE_W'(bus.arb_busy), '0);
    chk("i_resp_pulse",  LINE_W'(bus.icache_resp), '0);
    @(negedge clk);
    chk("i_no_regrant", LINE_W'(bus.pmem_read), '0);

    // Simultaneous I read and D write: D first, then I.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h0040;
    bus.dcache_write   = 1'b1;
    bus.dcache_address = 16'h2000;
    bus.dcache_wdata   = {8{16'h1111}};
    @(negedge clk);
    chk("both_write_strobe", LINE_W'(bus.pmem_write), LINE_W'(1));
    chk("both_read_low",     LINE_W'(bus.pmem_read), '0);
    chk("both_d_addr",       LINE_W'(bus.pmem_address), LINE_W'(16'h2000));
    chk("both_wdata",        bus.pmem_wdata, {8{16'h1111}});
    bus.pmem_resp = 1'b1;
    #1;
    chk("both_d_resp", LINE_W'(bus.dcache_resp), LINE_W'(1));
    chk("both_i_quiet", LINE_W'(bus.icache_resp), '0);
    @(negedge clk);
    bus.pmem_resp    = 1'b0;
    bus.dcache_write = 1'b0;
    chk("both_idle_gap", LINE_W'(bus.arb_busy), '0);
    @(negedge clk);
    chk("both_i_strobe", LINE_W'(bus.pmem_read), LINE_W'(1));
    chk("both_i_addr",   LINE_W'(bus.pmem_address), LINE_W'(16'h0040));
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {8{16'hBEEF}};
    #1;
    chk("both_i_resp",  LINE_W'(bus.icache_resp), LINE_W'(1));
    chk("both_i_rdata", bus.icache_rdata, {8{16'hBEEF}});
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    @(negedge clk);

    // Starvation limit: I held while D issues 5 reads -> D D D D I D.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h0100;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h5000;
    d_done = 0;
    for (int g = 0; g < 6; g++) begin
      serve_one(got_d, got_addr);
      chk($sformatf("streak_who_%0d", g), LINE_W'(got_d), LINE_W'(exp_d[g]));
      chk($sformatf("streak_addr_%0d", g), LINE_W'(got_addr),
          exp_d[g] ? LINE_W'(16'h5000 + 16'(d_done * 16)) : LINE_W'(16'h0100));
      if (got_d) begin
        d_done++;
        bus.dcache_address = 16'h5000 + 16'(d_done * 16);
        if (d_done == 5) bus.dcache_read = 1'b0;
      end else begin
        bus.icache_read = 1'b0;
      end
    end
    // Streak reset by the I grant: both requesting again must pick D.
    @(negedge clk);
    bus.icache_read    = 1'b1;
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h6000;
    serve_one(got_d, got_addr);
    chk("streak_cleared", LINE_W'(got_d), LINE_W'(1));
    bus.dcache_read = 1'b0;
    serve_one(got_d, got_addr);
    chk("streak_then_i", LINE_W'(got_d), LINE_W'(0));
    bus.icache_read = 1'b0;
    @(negedge clk);

    // Address held while requester changes it mid-transaction.
    bus.dcache_read    = 1'b1;
    bus.dcache_address = 16'h3000;
    @(negedge clk);
    chk("hold_addr0", LINE_W'(bus.pmem_address), LINE_W'(16'h3000));
    bus.dcache_address = 16'h4000;
    @(negedge clk);
    chk("hold_addr1", LINE_W'(bus.pmem_address), LINE_W'(16'h3000));
    chk("hold_strobe", LINE_W'(bus.pmem_read), LINE_W'(1));
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {4{32'h0BADF00D}};
    #1;
    chk("hold_resp",  LINE_W'(bus.dcache_resp), LINE_W'(1));
    chk("hold_rdata", bus.dcache_rdata, {4{32'h0BADF00D}});
    chk("hold_addr2", LINE_W'(bus.pmem_address), LINE_W'(16'h3000));
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.dcache_read = 1'b0;
    @(negedge clk);

    // Stray pmem_resp in IDLE.
    bus.pmem_resp = 1'b1;
    #1;
    chk("stray_i_resp", LINE_W'(bus.icache_resp), '0);
    chk("stray_d_resp", LINE_W'(bus.dcache_resp), '0);
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    chk("stray_idle",   LINE_W'(bus.arb_busy), '0);
    chk("stray_no_rd",  LINE_W'(bus.pmem_read), '0);

    // Asynchronous reset during SERVE_I.
    bus.icache_read    = 1'b1;
    bus.icache_address = 16'h7770;
    @(negedge clk);
    chk("abort_strobe_pre", LINE_W'(bus.pmem_read), LINE_W'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("abort_strobe_drop", LINE_W'(bus.pmem_read), '0);
    chk("abort_busy_drop",   LINE_W'(bus.arb_busy), '0);
    chk("abort_addr_clr",    LINE_W'(bus.pmem_address), '0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("abort_no_resp", LINE_W'(bus.icache_resp), '0);
    @(negedge clk);
    chk("abort_no_resp2", LINE_W'(bus.icache_resp), '0);
    bus.pmem_resp = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("regrant_strobe", LINE_W'(bus.pmem_read), LINE_W'(1));
    chk("regrant_addr",   LINE_W'(bus.pmem_address), LINE_W'(16'h7770));
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = {16{8'h3C}};
    #1;
    chk("regrant_resp",  LINE_W'(bus.icache_resp), LINE_W'(1));
    chk("regrant_rdata", bus.icache_rdata, {16{8'h3C}});
    @(negedge clk);
    bus.pmem_resp   = 1'b0;
    bus.icache_read = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical-memory port between the instruction-fetch cache (I-side) and the data cache (D-side).
- The D-side is fed by the EX/MEM stage's memory address and store data.
- Sequences one transaction at a time and routes the response back to the requester that owns the grant.
- Data requests have priority over fetches; a starvation counter guarantees forward progress for fetches.

Parameters:
- ADDR_W, 16, address width (lc3b_word).
- LINE_W, 128, memory line width.
- MAX_D_STREAK, 4, consecutive D grants allowed while an I request waits; then I is forced.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- icache_read  in  1  I-side read request; held until icache_resp.
- icache_address  in  ADDR_W  I-side line address.
- icache_rdata  out  LINE_W  read data to I-side.
- icache_resp  out  1  one-cycle completion pulse to I-side.
- dcache_read  in  1  D-side read request; held until dcache_resp.
- dcache_write  in  1  D-side write request; held until dcache_resp.
- dcache_address  in  ADDR_W  D-side line address.
- dcache_wdata  in  LINE_W  D-side write line.
- dcache_rdata  out  LINE_W  read data to D-side.
- dcache_resp  out  1  one-cycle completion pulse to D-side.
- pmem_read  out  1  memory read strobe.
- pmem_write  out  1  memory write strobe.
- pmem_address  out  ADDR_W  registered memory address.
- pmem_wdata  out  LINE_W  registered write line.
- pmem_rdata  in  LINE_W  memory read data.
- pmem_resp  in  1  memory completion pulse.
- arb_busy  out  1  high when state is not IDLE (for stall logic).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- On reset, the following clear immediately, without waiting for a clock edge:
  - state = IDLE, d_streak = 0;
  - pmem_read, pmem_write, arb_busy = 0;
  - pmem_address, pmem_wdata = 0;
  - icache_resp, dcache_resp = 0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE arbitration, evaluated at the clock edge (d_req = dcache_read | dcache_write):
  - d_req and !icache_read -> SERVE_D.
  - icache_read and !d_req -> SERVE_I.
  - both, d_streak < MAX_D_STREAK -> SERVE_D.
  - both, d_streak == MAX_D_STREAK -> SERVE_I.
  - neither -> stay in IDLE.
- Grant edge:
  - Register the granted requester's address into pmem_address.
  - For a D write, also register dcache_wdata into pmem_wdata.
  - The request type is latched: read or write.
  - The strobe is asserted from the cycle after the grant edge.
- dcache_read and dcache_write both high is illegal; the arbiter treats it as a write.
- SERVE_x: hold the strobe and the registered address/wdata until pmem_resp.
  - Requester inputs changing during SERVE_x are ignored.
  - On pmem_resp:
    - x_resp = 1 in the same cycle, combinationally (pmem_resp gated by the grant).
    - x_rdata = pmem_rdata, passed through.
    - Next state is IDLE; the strobe drops at that edge.
- The non-granted requester's resp is always 0.
- Its rdata is 0 outside its grant.
- pmem_resp in IDLE is ignored; no resp is generated.
- One mandatory IDLE cycle follows every response, so a requester dropping its request after resp is never re-granted.
- Back-to-back throughput: one transaction per (memory latency + 1 IDLE + 1 grant) cycles.
- d_streak update, at the grant edge:
  - D granted while icache_read is high -> d_streak + 1, saturating at MAX_D_STREAK.
  - I granted -> 0.
  - D granted with no I pending -> 0.
- arb_busy = (state != IDLE).
- Reset mid-transaction aborts: strobes drop asynchronously, no resp is issued, and requesters must re-request.

Test Plan:
- Reset, then a single I read of 0x1230, with pmem_resp 3 cycles after strobe and rdata 0xA5..A5:
  - pmem_read high 1 cycle after grant, pmem_address = 0x1230;
  - icache_resp one pulse with icache_rdata = 0xA5..A5;
  - dcache_resp stays 0.
- Simultaneous I read 0x0040 and D write 0x2000 with wdata 0x1111..:
  - D served first, pmem_write with pmem_wdata = 0x1111..;
  - one IDLE cycle, then I served.
- Streak test: I read held high while D issues 5 back-to-back reads, MAX_D_STREAK = 4:
  - grant order is D, D, D, D, I, D;
  - d_streak returns to 0 after the I grant.
- Requester changes dcache_address from 0x3000 to 0x4000 mid-SERVE_D:
  - pmem_address stays 0x3000 until resp.
- pmem_resp pulsed while IDLE with no requests:
  - no resp outputs, state stays IDLE.
- Reset asserted between clock edges during SERVE_I:
  - pmem_read drops before the next clk edge;
  - icache_resp never pulses;
  - after reset release, a held I request is re-granted.
